bus_mem_responder: RTL and testbench
====================================

BUS_MEM_RESPONDER -- requirements
Module: bus_mem_responder

Interface
REQ-001 SHALL have parameter BASE, default 0: first word address claimed by this responder.
REQ-002 SHALL have parameter DEPTH, default 256: number of words stored; power of two, 2..4096.
REQ-003 SHALL have parameter RD_LAT, default 2: cycles from read acceptance to read_dn; range 1..15.
REQ-004 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port addr_in, input, `ADDR_SIZE0+1: word address from the bus initiator.
REQ-007 SHALL have port data_in, input, `DATA_SIZE0+1: write data from the bus initiator.
REQ-008 SHALL have port read_q, input, 1: read request level.
REQ-009 SHALL have port write_q, input, 1: write request level.
REQ-010 SHALL have port halt_q_in, input, 1: bus hold; blocks new acceptances and freezes the latency counter.
REQ-011 SHALL have port data_out, output, `DATA_SIZE0+1: read data; all-zero whenever read_dn=0, so it can be OR-merged onto the bus.
REQ-012 SHALL have port read_dn, output, 1: read done.
REQ-013 SHALL have port write_dn, output, 1: write done.
REQ-014 SHALL have port bus_busy, output, 1: high in every state except IDLE.
REQ-015 SHALL have port proto_err, output, 1: one-cycle pulse when a protocol error is detected.

Function
REQ-016 SHALL hit when BASE <= addr_in < BASE+DEPTH; word index = addr_in-BASE, computed at full address width with no wrap-around.
REQ-017 SHALL implement states IDLE, RD_WAIT, RD_DONE and WR_DONE; every output is registered.
REQ-018 IDLE: if halt_q_in=0, read_q=1, write_q=0 and the address hits, SHALL latch the index, load the counter with RD_LAT-1 and go to RD_WAIT.
REQ-019 IDLE: if halt_q_in=0, write_q=1, read_q=0 and the address hits, SHALL write data_in to the indexed word on that edge and go to WR_DONE.
REQ-020 IDLE: if read_q=1 and write_q=1 together with a hit, SHALL pulse proto_err for one cycle, stay in IDLE and perform no memory access.
REQ-021 IDLE: on a miss, SHALL ignore the request, keep all outputs 0 and leave proto_err low.
REQ-022 RD_WAIT: the counter SHALL decrement only while halt_q_in=0; when it reaches 0, the next edge loads mem[index] into data_out, sets read_dn=1 and enters RD_DONE; total latency from acceptance to read_dn = RD_LAT cycles with no halt.
REQ-023 RD_WAIT: if read_q drops, SHALL abort to IDLE with no read_dn and no proto_err.
REQ-024 RD_DONE: SHALL hold read_dn=1 and data_out stable until read_q=0, then on the next edge clear both and return to IDLE.
REQ-025 WR_DONE: write_dn=1 from the cycle after acceptance; held until write_q=0, then cleared on the next edge with a return to IDLE.
REQ-026 SHALL accept no new request in the same cycle it returns to IDLE; minimum request spacing is one idle cycle.
REQ-027 SHALL ignore addr_in and data_in changes after acceptance; the latched index is used.
REQ-028 SHALL ignore halt_q_in in RD_DONE and WR_DONE.
REQ-029 SHALL use single-port memory: one read or one write per cycle, never both.

Reset
REQ-030 With rst=0 at an edge, SHALL go to IDLE and force read_dn, write_dn, bus_busy and proto_err to 0 and data_out to all-zero, including mid-transaction.
REQ-031 SHALL NOT clear memory contents on reset; a write completed before reset SHALL remain readable.

Verification
REQ-032 Write then read: write 0xDEADBEEF to BASE+5; one cycle later write_dn=1; drop write_q; read BASE+5 -> read_dn exactly RD_LAT=2 cycles after acceptance, data_out=0xDEADBEEF.
REQ-033 Halt stretch: hold halt_q_in=1 for 3 cycles during RD_WAIT -> read_dn appears at RD_LAT+3 cycles; data is correct.
REQ-034 Window edges: read BASE+DEPTH-1 -> served; read BASE+DEPTH and BASE-1 -> no dn, bus_busy stays 0, data_out=0.
REQ-035 Collision/abort: read_q and write_q together at a hit -> proto_err pulses once with no dn; read_q dropped in RD_WAIT -> IDLE with no read_dn.
REQ-036 Reset mid-read: rst=0 in RD_WAIT -> all outputs 0 the next cycle; after release, a reread of a previously written word returns the old value.

Source files
------------

// File: rtl/bus_mem_responder.sv
// ---------------------------------------------------------------------------
// bus_mem_responder
//
// Word-addressed memory slave on a simple request/done bus. It claims the
// address window [BASE, BASE+DEPTH). Writes complete one cycle after
// acceptance. Reads complete RD_LAT cycles after acceptance, and halt cycles
// stretch that latency. Every output is registered. data_out is all-zero
// whenever read_dn is low, so several responders can be OR-merged onto one
// shared bus.
//
// Parameters
//   BASE    first word address claimed
//   DEPTH   number of stored words (power of two, 2..4096)
//   RD_LAT  cycles from read acceptance to read_dn (1..15)
//
// Ports
//   clk        clock; every state change happens on its rising edge
//   rst        synchronous reset, active low (memory contents are kept)
//   addr_in    word address from the initiator
//   data_in    write data from the initiator
//   read_q     read request level
//   write_q    write request level
//   halt_q_in  bus hold: blocks acceptance, freezes the read latency count
//   data_out   read data, zero unless read_dn is high
//   read_dn    read done, held until read_q drops
//   write_dn   write done, held until write_q drops
//   bus_busy   high whenever the FSM is outside IDLE
//   proto_err  one-cycle pulse on a read+write collision at a hit
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

`ifndef ADDR_SIZE0
`define ADDR_SIZE0 15
`endif
`ifndef DATA_SIZE0
`define DATA_SIZE0 31
`endif

module bus_mem_responder #(
   parameter int unsigned BASE   = 0,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned RD_LAT = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [`ADDR_SIZE0:0]   addr_in,
   input  logic [`DATA_SIZE0:0]   data_in,
   input  logic                   read_q,
   input  logic                   write_q,
   input  logic                   halt_q_in,
   output logic [`DATA_SIZE0:0]   data_out,
   output logic                   read_dn,
   output logic                   write_dn,
   output logic                   bus_busy,
   output logic                   proto_err
);

   localparam int unsigned AW    = `ADDR_SIZE0 + 1;
   localparam int unsigned DW    = `DATA_SIZE0 + 1;
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Window bounds carry one extra bit so BASE+DEPTH never wraps.
   localparam logic [AW:0] LP_LO       = (AW+1)'(BASE);
   localparam logic [AW:0] LP_HI       = (AW+1)'(BASE + DEPTH);
   localparam logic [3:0]  LP_CNT_INIT = 4'(RD_LAT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RD_WAIT,
      ST_RD_DONE,
      ST_WR_DONE
   } state_t;

   // -------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------
   state_t              r_state;
   logic [IDX_W-1:0]    r_idx;
   logic [3:0]          r_cnt;
   logic                r_rd_dn;
   logic                r_wr_dn;
   logic                r_busy;
   logic                r_perr;
   logic [DW-1:0]       r_dout;
   logic [DW-1:0]       r_mem [DEPTH];

   // -------------------------------------------------------------------
   // Combinational next-state / next-output signals
   // -------------------------------------------------------------------
   state_t              w_state_nxt;
   logic [IDX_W-1:0]    w_idx_nxt;
   logic [3:0]          w_cnt_nxt;
   logic                w_rd_dn_nxt;
   logic                w_wr_dn_nxt;
   logic                w_perr_nxt;
   logic [DW-1:0]       w_dout_nxt;
   logic                w_mem_we;

   logic [AW:0]         w_addr_x;
   logic                w_hit;
   logic [IDX_W-1:0]    w_idx;
   logic [DW-1:0]       w_mem_rdata;

   // Address decode at full width plus one: an address just above the
   // window cannot alias back onto index 0.
   assign w_addr_x    = {1'b0, addr_in};
   assign w_hit       = (w_addr_x >= LP_LO) && (w_addr_x < LP_HI);
   assign w_idx       = IDX_W'(w_addr_x - LP_LO);

   // The only read port, and it is used only in RD_WAIT; the write port is
   // used only in IDLE, so the array never sees a read and a write together.
   assign w_mem_rdata = r_mem[r_idx];

   // -------------------------------------------------------------------
   // Next-state and output logic
   // -------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = r_cnt;
      w_rd_dn_nxt = 1'b0;
      w_wr_dn_nxt = 1'b0;
      w_perr_nxt  = 1'b0;
      w_dout_nxt  = '0;
      w_mem_we    = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_hit) begin
               if (read_q && write_q) begin
                  // Collision: flag it and leave the memory untouched.
                  w_perr_nxt = 1'b1;
               end else if (!halt_q_in && read_q) begin
                  w_idx_nxt   = w_idx;
                  w_cnt_nxt   = LP_CNT_INIT;
                  w_state_nxt = ST_RD_WAIT;
               end else if (!halt_q_in && write_q) begin
                  w_mem_we    = 1'b1;
                  w_wr_dn_nxt = 1'b1;
                  w_state_nxt = ST_WR_DONE;
               end
            end
         end

         ST_RD_WAIT: begin
            if (!read_q) begin
               w_state_nxt = ST_IDLE;
            end else if (!halt_q_in) begin
               // Halt freezes both the count and the final load, so every
               // halted cycle adds exactly one cycle of latency.
               if (r_cnt == 4'd0) begin
                  w_dout_nxt  = w_mem_rdata;
                  w_rd_dn_nxt = 1'b1;
                  w_state_nxt = ST_RD_DONE;
               end else begin
                  w_cnt_nxt = r_cnt - 4'd1;
               end
            end
         end

         ST_RD_DONE: begin
            if (read_q) begin
               w_rd_dn_nxt = 1'b1;
               w_dout_nxt  = r_dout;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end

         ST_WR_DONE: begin
            if (write_q) begin
               w_wr_dn_nxt = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------
   // State and output registers
   // -------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_rd_dn <= 1'b0;
         r_wr_dn <= 1'b0;
         r_busy  <= 1'b0;
         r_perr  <= 1'b0;
         r_dout  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_cnt   <= w_cnt_nxt;
         r_rd_dn <= w_rd_dn_nxt;
         r_wr_dn <= w_wr_dn_nxt;
         r_busy  <= (w_state_nxt != ST_IDLE);
         r_perr  <= w_perr_nxt;
         r_dout  <= w_dout_nxt;
      end
   end

   // Storage is never reset; only the write enable is gated by reset.
   always_ff @(posedge clk) begin
      if (rst && w_mem_we) begin
         r_mem[w_idx] <= data_in;
      end
   end

   assign data_out  = r_dout;
   assign read_dn   = r_rd_dn;
   assign write_dn  = r_wr_dn;
   assign bus_busy  = r_busy;
   assign proto_err = r_perr;

endmodule

// File: tb/tb_bus_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_bus_mem_responder
//
// Scoreboard bench for bus_mem_responder (BASE=0x100, DEPTH=16, RD_LAT=2).
// Stimulus pushes the expected done/error event (kind, data, cycle) into a
// queue; a negedge monitor pops and checks each event the DUT raises. The
// monitor also checks that data_out is zero without read_dn and stays stable
// while read_dn is held.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

`ifndef ADDR_SIZE0
`define ADDR_SIZE0 15
`endif
`ifndef DATA_SIZE0
`define DATA_SIZE0 31
`endif

module tb_bus_mem_responder;

   localparam int unsigned P_BASE  = 32'h100;
   localparam int unsigned P_DEPTH = 16;
   localparam int unsigned P_LAT   = 2;

   localparam int K_RD = 1;
   localparam int K_WR = 2;
   localparam int K_PE = 3;

   typedef struct {
      int          kind;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [`ADDR_SIZE0:0] addr_in;
   logic [`DATA_SIZE0:0] data_in;
   logic                 read_q;
   logic                 write_q;
   logic                 halt_q_in;
   logic [`DATA_SIZE0:0] data_out;
   logic                 read_dn;
   logic                 write_dn;
   logic                 bus_busy;
   logic                 proto_err;

   bus_mem_responder #(
      .BASE   (P_BASE),
      .DEPTH  (P_DEPTH),
      .RD_LAT (P_LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .addr_in   (addr_in),
      .data_in   (data_in),
      .read_q    (read_q),
      .write_q   (write_q),
      .halt_q_in (halt_q_in),
      .data_out  (data_out),
      .read_dn   (read_dn),
      .write_dn  (write_dn),
      .bus_busy  (bus_busy),
      .proto_err (proto_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t sb[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic push(input int kind, input logic [31:0] data, input int at);
      exp_t e;
      e.kind = kind;
      e.data = data;
      e.cyc  = at;
      sb.push_back(e);
   endtask

   // ---------------- monitor ----------------
   bit          mon_en = 1'b0;
   logic        p_rd   = 1'b0;
   logic        p_wr   = 1'b0;
   logic [31:0] p_dout = '0;

   task automatic match(input int kind, input logic [31:0] data);
      exp_t e;
      chk("event_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("event_kind", 32'(kind), 32'(e.kind));
         chk("event_cycle", 32'(cyc), 32'(e.cyc));
         if (kind == K_RD) chk("read_data", data, e.data);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (read_dn && !p_rd) match(K_RD, data_out);
         if (read_dn && p_rd)  chk("dout_stable", data_out, p_dout);
         if (!read_dn)         chk("dout_zero_idle", data_out, 32'd0);
         if (write_dn && !p_wr) match(K_WR, 32'd0);
         if (proto_err)        match(K_PE, 32'd0);
         p_rd   = read_dn;
         p_wr   = write_dn;
         p_dout = data_out;
      end
   end

   // ---------------- stimulus helpers (called at a negedge) ----------------
   task automatic wait_dn(input bit rd);
      bit got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (rd ? read_dn : write_dn) begin
            got = 1'b1;
            break;
         end
      end
      chk(rd ? "read_dn_seen" : "write_dn_seen", 32'(got), 32'd1);
   endtask

   task automatic do_write(input logic [15:0] a, input logic [31:0] d);
      addr_in = a;
      data_in = d;
      write_q = 1'b1;
      push(K_WR, 32'd0, cyc + 1);
      wait_dn(1'b0);
      data_in = ~d;
      write_q = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic do_read(input logic [15:0] a, input logic [31:0] d, input int h);
      addr_in = a;
      read_q  = 1'b1;
      push(K_RD, d, cyc + 1 + int'(P_LAT) + h);
      @(negedge clk);
      addr_in = a ^ 16'h0003;  // must not affect the latched index
      if (h > 0) begin
         halt_q_in = 1'b1;
         repeat (h) @(negedge clk);
         halt_q_in = 1'b0;
      end
      wait_dn(1'b1);
      @(negedge clk);
      read_q = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic no_resp(input logic [15:0] a, input bit rd, input bit wr);
      addr_in = a;
      data_in = 32'h5555_5555;
      read_q  = rd;
      write_q = wr;
      repeat (3) begin
         @(negedge clk);
         chk("miss_busy", 32'(bus_busy), 32'd0);
         chk("miss_dn", 32'({read_dn, write_dn, proto_err}), 32'd0);
      end
      read_q  = 1'b0;
      write_q = 1'b0;
      @(negedge clk);
   endtask

   task automatic chk_all_zero(input string nm);
      chk(nm, 32'({read_dn, write_dn, bus_busy, proto_err}), 32'd0);
      chk(nm, data_out, 32'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst       = 1'b0;
      addr_in   = '0;
      data_in   = '0;
      read_q    = 1'b0;
      write_q   = 1'b0;
      halt_q_in = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset_state");
      mon_en = 1'b1;
      rst    = 1'b1;
      @(negedge clk);

      // Writes, then reads with default and halted latency.
      do_write(16'(P_BASE + 5),  32'hDEAD_BEEF);
      do_write(16'(P_BASE + 2),  32'h2222_2222);
      do_write(16'(P_BASE + 0),  32'hA0A0_A0A0);
      do_write(16'(P_BASE + 15), 32'hF00D_F00D);
      do_read (16'(P_BASE + 5),  32'hDEAD_BEEF, 0);
      do_read (16'(P_BASE + 5),  32'hDEAD_BEEF, 3);

      // Window edges: last word served, one past and one before ignored.
      do_read (16'(P_BASE + P_DEPTH - 1), 32'hF00D_F00D, 0);
      no_resp (16'(P_BASE + P_DEPTH), 1'b1, 1'b0);
      no_resp (16'(P_BASE - 1),       1'b1, 1'b0);
      no_resp (16'(P_BASE + P_DEPTH), 1'b0, 1'b1);
      do_read (16'(P_BASE + 0), 32'hA0A0_A0A0, 0);

      // Collision at a hit: single proto_err, no write.
      addr_in = 16'(P_BASE + 2);
      data_in = 32'hBAD0_BAD0;
      read_q  = 1'b1;
      write_q = 1'b1;
      push(K_PE, 32'd0, cyc + 1);
      @(negedge clk);
      read_q  = 1'b0;
      write_q = 1'b0;
      @(negedge clk);
      chk("collision_busy", 32'(bus_busy), 32'd0);
      do_read(16'(P_BASE + 2), 32'h2222_2222, 0);

      // Collision at a miss: silent.
      no_resp(16'(P_BASE - 1), 1'b1, 1'b1);

      // Abort in RD_WAIT.
      addr_in = 16'(P_BASE + 5);
      read_q  = 1'b1;
      @(negedge clk);
      chk("rdwait_busy", 32'(bus_busy), 32'd1);
      read_q = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_busy", 32'(bus_busy), 32'd0);

      // Halt blocks acceptance for two cycles.
      addr_in   = 16'(P_BASE + 15);
      read_q    = 1'b1;
      halt_q_in = 1'b1;
      push(K_RD, 32'hF00D_F00D, cyc + 1 + 2 + int'(P_LAT));
      repeat (2) @(negedge clk);
      chk("halt_no_accept", 32'(bus_busy), 32'd0);
      halt_q_in = 1'b0;
      wait_dn(1'b1);
      read_q = 1'b0;
      repeat (2) @(negedge clk);

      // Reset in RD_WAIT, then reread an old word.
      do_write(16'(P_BASE + 7), 32'h1234_5678);
      addr_in = 16'(P_BASE + 7);
      read_q  = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_all_zero("reset_mid_read");
      read_q = 1'b0;
      rst    = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_reset_busy", 32'(bus_busy), 32'd0);
      do_read(16'(P_BASE + 7), 32'h1234_5678, 0);
      do_read(16'(P_BASE + 5), 32'hDEAD_BEEF, 0);

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
